// File: rtl/sha256_pkg.sv
// Shared digest/nonce constants, the word-select macro and the pointer-width helper.
// Word 0 is hash[31:0]; word 7 is hash[255:224].
`ifndef SHA256_PKG_SV
`define SHA256_PKG_SV

`define IDX(x) ((x)*32) +: 32

package sha256_pkg;

    localparam int NONCE_W  = 32;
    localparam int DIGEST_W = 256;

    typedef struct packed {
        logic               match;
        logic [NONCE_W-1:0] cand;
    } s1_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

`endif

// File: rtl/sha256_golden_filter_fifo.sv
// golden_fifo: DEPTH x W first-word-fall-through queue with flush and simultaneous push/pop.
// Latency: a push is visible on rdata the cycle after it is written.
// Backpressure: a push while full is refused unless a pop frees the slot in the same cycle.
module golden_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         wr_en;
    logic         rd_en;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: rdata is forced to zero whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/sha256_golden_filter.sv
// sha256_golden_filter: tags each final digest with its nonce, queues nonces meeting the share target.
// Latency: hash_valid -> out_valid 2 cycles. Backpressure: out_valid/out_ready; full queue drops and sets overflow.
// GOLDEN_DIFFICULTY_EN adds target_zeros (leading zero bits of word 7); otherwise all of word 7 must be zero.
module sha256_golden_filter
    import sha256_pkg::*;
#(
    parameter logic [31:0] NONCE_LAG = 32'd0,
    parameter int          DEPTH     = 4,
    parameter int          AW        = clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                work_start,
    input  logic                hash_valid,
    input  logic [DIGEST_W-1:0] hash,
`ifdef GOLDEN_DIFFICULTY_EN
    input  logic [5:0]          target_zeros,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NONCE_W-1:0]  out_nonce,
    output logic                overflow,
    output logic [31:0]         hash_count
);

    logic [NONCE_W-1:0] nonce_cnt_q, nonce_cnt_d;
    logic [31:0]        hash_count_q, hash_count_d;
    logic               overflow_q, overflow_d;
    s1_t                s1_q, s1_d;

    logic [31:0]        word7;
    logic               match;
    logic               accept;
    logic [NONCE_W-1:0] candidate;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic               drop;
    logic               unused_hash_bits;

    assign word7            = hash[`IDX(7)];
    assign unused_hash_bits = ^hash[223:0];
    assign accept           = hash_valid && !work_start;
    assign candidate        = nonce_cnt_q - NONCE_LAG;

`ifdef GOLDEN_DIFFICULTY_EN
    logic [5:0]  tz_sat;
    logic [31:0] zero_mask;

    // Shifting by 32 yields zero, so a saturated target masks the whole word.
    assign tz_sat    = (target_zeros > 6'd32) ? 6'd32 : target_zeros;
    assign zero_mask = ~(32'hFFFF_FFFF >> tz_sat);
    assign match     = ((word7 & zero_mask) == 32'h0);
`else
    assign match     = (word7 == 32'h0);
`endif

    assign fifo_pop  = out_valid && out_ready;
    assign fifo_push = s1_q.match && !work_start;
    assign drop      = fifo_push && fifo_full && !fifo_pop;

    always_comb begin
        nonce_cnt_d  = nonce_cnt_q;
        hash_count_d = hash_count_q;
        overflow_d   = overflow_q;
        s1_d         = s1_q;
        if (work_start) begin
            nonce_cnt_d  = '0;
            hash_count_d = '0;
            overflow_d   = 1'b0;
            s1_d         = '0;
        end else begin
            s1_d.match = accept && match;
            if (accept) begin
                s1_d.cand    = candidate;
                nonce_cnt_d  = nonce_cnt_q + 1'b1;
                hash_count_d = hash_count_q + 1'b1;
            end
            if (drop) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nonce_cnt_q  <= '0;
            hash_count_q <= '0;
            overflow_q   <= 1'b0;
            s1_q         <= '0;
        end else begin
            nonce_cnt_q  <= nonce_cnt_d;
            hash_count_q <= hash_count_d;
            overflow_q   <= overflow_d;
            s1_q         <= s1_d;
        end
    end

    golden_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (NONCE_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (work_start),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (s1_q.cand),
        .rdata (out_nonce),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid  = !fifo_empty;
    assign overflow   = overflow_q;
    assign hash_count = hash_count_q;

endmodule

// File: tb/tb_sha256_golden_filter.sv
// Directed + randomized bench for sha256_golden_filter against a queue-based reference model.
// Model: a nonce becomes eligible for the queue one edge after its digest is accepted.
module tb_sha256_golden_filter;

    localparam logic [31:0] LAG   = 32'd2;
    localparam int          DEPTH = 4;

    logic         clk;
    logic         reset;
    logic         work_start;
    logic         hash_valid;
    logic [255:0] hash;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_nonce;
    logic         overflow;
    logic [31:0]  hash_count;
`ifdef GOLDEN_DIFFICULTY_EN
    logic [5:0]   target_zeros;
`endif

    int vectors;
    int miscompares;

    // Reference model state
    logic [31:0] m_cnt;
    logic [31:0] m_hcnt;
    bit          m_ovf;
    logic [31:0] m_q[$];
    bit          m_pend_vld;
    logic [31:0] m_pend_nonce;
    int          m_tz;

    sha256_golden_filter #(
        .NONCE_LAG (LAG),
        .DEPTH     (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .work_start   (work_start),
        .hash_valid   (hash_valid),
        .hash         (hash),
`ifdef GOLDEN_DIFFICULTY_EN
        .target_zeros (target_zeros),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_nonce    (out_nonce),
        .overflow     (overflow),
        .hash_count   (hash_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_match(input logic [31:0] w, input int tzv);
        int lz;
        int need;
        lz = 0;
        while (lz < 32 && !w[31-lz]) lz++;
        need = (tzv > 32) ? 32 : tzv;
        return lz >= need;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = '0;
        m_hcnt = '0;
        m_ovf = 0;
        m_q.delete();
        m_pend_vld = 0;
        m_pend_nonce = '0;
    endtask

    task automatic model_edge(input logic hv, input logic [31:0] w7, input logic ws, input logic rdy);
        bit popm;
        popm = (m_q.size() > 0) && rdy;
        if (ws) begin
            model_reset();
        end else begin
            if (popm) void'(m_q.pop_front());
            if (m_pend_vld) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_pend_nonce);
                else m_ovf = 1;
            end
            m_pend_vld   = hv && m_match(w7, m_tz);
            m_pend_nonce = m_cnt - LAG;
            if (hv) begin
                m_cnt  = m_cnt + 1;
                m_hcnt = m_hcnt + 1;
            end
        end
    endtask

    task automatic check_all();
        check("out_valid", {31'b0, out_valid}, {31'b0, m_q.size() > 0});
        check("out_nonce", out_nonce, (m_q.size() > 0) ? m_q[0] : 32'h0);
        check("overflow", {31'b0, overflow}, {31'b0, m_ovf});
        check("hash_count", hash_count, m_hcnt);
    endtask

    task automatic cyc(input logic hv, input logic [31:0] w7, input logic ws, input logic rdy);
        hash_valid = hv;
        hash       = {w7, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        work_start = ws;
        out_ready  = rdy;
        @(posedge clk);
        model_edge(hv, w7, ws, rdy);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_tz        = 32;
        reset       = 1'b1;
        work_start  = 1'b0;
        hash_valid  = 1'b0;
        hash        = '0;
        out_ready   = 1'b0;
`ifdef GOLDEN_DIFFICULTY_EN
        target_zeros = 6'd32;
`endif
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        reset = 1'b0;

        // 1: non-golden digests only
        cyc(0, 32'h0, 1, 0);
        for (int i = 0; i < 5; i++) cyc(1, $urandom | 32'h1, 0, 0);
        cyc(0, 32'h0, 0, 0);
        check("t1_count", hash_count, 32'd5);
        check("t1_valid", {31'b0, out_valid}, 32'd0);

        // 2: fourth accepted digest is golden -> nonce 3 - LAG
        cyc(0, 32'h0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1, $urandom | 32'h8000_0000, 0, 0);
        cyc(1, 32'h0, 0, 0);
        check("t2_valid_n1", {31'b0, out_valid}, 32'd0);
        cyc(0, 32'h0, 0, 0);
        check("t2_valid_n2", {31'b0, out_valid}, 32'd1);
        check("t2_nonce", out_nonce, 32'h1);
        cyc(0, 32'h0, 0, 1);

        // 3: six goldens into a 4-deep queue, then drain
        cyc(0, 32'h0, 1, 0);
        for (int i = 0; i < 6; i++) cyc(1, 32'h0, 0, 0);
        cyc(0, 32'h0, 0, 0);
        cyc(0, 32'h0, 0, 0);
        check("t3_ovf", {31'b0, overflow}, 32'd1);
        check("t3_head", out_nonce, 32'hFFFF_FFFE);
        for (int i = 0; i < 4; i++) cyc(0, 32'h0, 0, 1);
        check("t3_empty", {31'b0, out_valid}, 32'd0);

        // 4: full queue, golden reaches the queue while popping
        cyc(0, 32'h0, 1, 0);
        for (int i = 0; i < 5; i++) cyc(1, 32'h0, 0, 0);
        cyc(0, 32'h0, 0, 1);
        check("t4_ovf", {31'b0, overflow}, 32'd0);
        check("t4_head", out_nonce, 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) cyc(0, 32'h0, 0, 1);
        check("t4_last_empty", {31'b0, out_valid}, 32'd0);

        // 5: work_start with a golden in flight and one arriving
        cyc(0, 32'h0, 1, 0);
        cyc(1, 32'h0, 0, 0);
        cyc(1, 32'h0, 1, 0);
        cyc(0, 32'h0, 0, 0);
        check("t5_flushed", {31'b0, out_valid}, 32'd0);
        cyc(1, 32'h0, 0, 0);
        cyc(0, 32'h0, 0, 0);
        check("t5_restart", out_nonce, 32'hFFFF_FFFE);
        cyc(0, 32'h0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            cyc($urandom_range(0, 1), ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom,
                $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0);
        end

        // Asynchronous reset mid-operation
        cyc(0, 32'h0, 1, 0);
        cyc(1, 32'h0, 0, 0);
        cyc(1, 32'h0, 0, 0);
        cyc(0, 32'h0, 0, 0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_nonce", out_nonce, 32'h0);
        check("rst_count", hash_count, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        cyc(1, 32'h0, 0, 0);
        cyc(0, 32'h0, 0, 0);
        check("rst_nonce_restart", out_nonce, 32'hFFFF_FFFE);
        cyc(0, 32'h0, 0, 1);

`ifdef GOLDEN_DIFFICULTY_EN
        // 6: programmable difficulty
        target_zeros = 6'd8;
        m_tz = 8;
        cyc(0, 32'h0, 1, 0);
        cyc(1, 32'h00FF_FFFF, 0, 0);
        cyc(1, 32'h01FF_FFFF, 0, 0);
        cyc(0, 32'h0, 0, 0);
        check("t6_head", out_nonce, 32'hFFFF_FFFE);
        cyc(0, 32'h0, 0, 1);
        check("t6_one_only", {31'b0, out_valid}, 32'd0);
        target_zeros = 6'd40;
        m_tz = 40;
        cyc(1, 32'h0000_0001, 0, 0);
        cyc(1, 32'h0, 0, 0);
        cyc(0, 32'h0, 0, 0);
        check("t6_sat_head", out_nonce, 32'h0000_0001);
        target_zeros = 6'd0;
        m_tz = 0;
        cyc(1, 32'hFFFF_FFFF, 0, 1);
        cyc(0, 32'h0, 0, 1);
        cyc(0, 32'h0, 0, 1);
        target_zeros = 6'd32;
        m_tz = 32;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
